// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory port of the fetch stage: request/grant issue side plus in-order response side.
interface fetch_prefetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: issues PC requests to a variable-latency memory, buffers responses in a prefetch FIFO
// for decode, and handles stall plus branch redirect with discard of in-flight responses.
module fetch_prefetch_queue #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           QUEUE_DEPTH     = 4,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  pc_branch_d,
  input  logic                   pc_src_d,
  input  logic                   stall_f,
  fetch_prefetch_queue_if.master imem,
  output logic                   valid_f,
  output logic [DATA_WIDTH-1:0]  instruction_f,
  output logic [ADDR_WIDTH-1:0]  pc_plus_4_f
);

  localparam int unsigned QIDX_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned AIDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SUM_W  = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CNT_W-1:0]      count;
  logic [OUT_W-1:0]      outstanding;
  logic [OUT_W-1:0]      outstanding_next;
  logic [OUT_W-1:0]      drop;
  logic [QIDX_W-1:0]     q_rd;
  logic [QIDX_W-1:0]     q_wr;
  logic [AIDX_W-1:0]     a_rd;
  logic [AIDX_W-1:0]     a_wr;

  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] a_fifo [MAX_OUTSTANDING];

  logic                  accept;
  logic                  resp;
  logic                  drop_hit;
  logic                  push;
  logic                  pop;
  logic                  has_room;
  logic [ADDR_WIDTH-1:0] resp_pc4;
  logic [ADDR_WIDTH-1:0] branch_aligned;

  // Room is reserved for every in-flight request, so a full queue can never be overrun.
  assign has_room = (SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(QUEUE_DEPTH);

  assign imem.imem_req  = reset_n & has_room & (outstanding < OUT_W'(MAX_OUTSTANDING)) & ~pc_src_d;
  assign imem.imem_addr = fetch_pc;

  assign accept         = imem.imem_req & imem.imem_gnt;
  assign resp           = imem.imem_rvalid;
  assign drop_hit       = resp & (drop != '0);
  assign push           = resp & ~drop_hit & ~pc_src_d;
  assign pop            = valid_f & ~stall_f & ~pc_src_d;
  assign resp_pc4       = a_fifo[a_rd] + ADDR_WIDTH'(4);
  assign branch_aligned = pc_branch_d & ~ADDR_WIDTH'(3);

  assign valid_f       = (count != '0);
  assign instruction_f = valid_f ? q_data[q_rd] : '0;
  assign pc_plus_4_f   = valid_f ? q_pc[q_rd]   : '0;

  always_comb begin
    outstanding_next = outstanding;
    if (accept && !resp) begin
      outstanding_next = outstanding + OUT_W'(1);
    end else if (!accept && resp) begin
      outstanding_next = outstanding - OUT_W'(1);
    end
  end

  function automatic logic [AIDX_W-1:0] a_inc(input logic [AIDX_W-1:0] idx);
    return (idx == AIDX_W'(MAX_OUTSTANDING - 1)) ? '0 : idx + AIDX_W'(1);
  endfunction

  // Control state; redirect wins over issue, push and pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_VECTOR;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      a_rd        <= '0;
      a_wr        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (accept) a_wr <= a_inc(a_wr);
      if (resp)   a_rd <= a_inc(a_rd);

      if (pc_src_d) begin
        fetch_pc <= branch_aligned;
        drop     <= outstanding_next;
        count    <= '0;
        q_rd     <= '0;
        q_wr     <= '0;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        if (drop_hit) drop     <= drop - OUT_W'(1);
        if (push)     q_wr     <= q_wr + QIDX_W'(1);
        if (pop)      q_rd     <= q_rd + QIDX_W'(1);
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Payload storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clock) begin
    if (push) begin
      q_data[q_wr] <= imem.imem_rdata;
      q_pc[q_wr]   <= resp_pc4;
    end
    if (accept) begin
      a_fifo[a_wr] <= fetch_pc;
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
    count <= CNT_W'(QUEUE_DEPTH));
  a_outstanding_bound: assert property (@(posedge clock) disable iff (!reset_n)
    outstanding <= OUT_W'(MAX_OUTSTANDING));
  a_drop_bound: assert property (@(posedge clock) disable iff (!reset_n)
    drop <= outstanding);
  a_no_orphan_resp: assert property (@(posedge clock) disable iff (!reset_n)
    resp |-> (outstanding != '0));

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Parametrised next-generation instruction fetch stage. It decouples the PC from instruction memory through a request/grant + response-valid memory port with variable latency and several outstanding requests. Fetched words go into a QUEUE_DEPTH-entry prefetch FIFO that feeds decode. It supports stall from hazard logic and branch redirect from decode, with flush and discard of in-flight responses. Sits between the program-counter/branch logic and the decode pipeline register.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction width
QUEUE_DEPTH, 4, prefetch FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, max granted-but-unanswered memory requests (>=1)
RESET_VECTOR, 0, PC after reset (word aligned)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
pc_branch_d  input  ADDR_WIDTH  redirect target from decode
pc_src_d  input  1  redirect strobe (1 = take pc_branch_d)
stall_f  input  1  decode not accepting; hold head entry
imem_req  output  1  memory request valid
imem_addr  output  ADDR_WIDTH  request address (word aligned)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid (in request order)
imem_rdata  input  DATA_WIDTH  response instruction
valid_f  output  1  instruction_f/pc_plus_4_f hold a valid entry
instruction_f  output  DATA_WIDTH  head-of-queue instruction
pc_plus_4_f  output  ADDR_WIDTH  head-of-queue address + 4

Behaviour:
- Reset (async, reset_n=0): fetch_pc=RESET_VECTOR; queue empty; outstanding=0; drop=0; imem_req=0; valid_f=0; instruction_f=0; pc_plus_4_f=0.
- Issue: imem_req=1 iff reset_n=1 and (count + outstanding) < QUEUE_DEPTH and outstanding < MAX_OUTSTANDING and pc_src_d=0. imem_addr=fetch_pc. Accept = imem_req & imem_gnt -> fetch_pc += 4 (mod 2^ADDR_WIDTH, wraps silently), outstanding += 1.
- Address may change while imem_req=1 and not granted (only via redirect); the memory must sample on the grant cycle only.
- Response: imem_rvalid arrives at the earliest one cycle after its grant, in order; outstanding -= 1. If drop>0: discard, drop -= 1. Else push {imem_rdata, addr+4} into FIFO. The per-entry address is the issue address tracked through a small in-order address FIFO of MAX_OUTSTANDING entries.
- Same-cycle grant and response: outstanding unchanged.
- Output: valid_f=(count!=0); instruction_f/pc_plus_4_f = head entry, 0 when empty. Pop when valid_f & ~stall_f. Push and pop in the same cycle are legal at any occupancy, including full. A full queue cannot overflow because of the issue rule.
- Redirect (pc_src_d=1), which has priority over everything:
  - fetch_pc <= {pc_branch_d[ADDR_WIDTH-1:2], 2'b00}.
  - Queue flushed, so valid_f=0 next cycle.
  - imem_req forced 0 this cycle.
  - drop <= outstanding_next, i.e. every request outstanding after this edge, including one whose response arrives this same cycle. That response is discarded, not pushed.
  - First fetch from the target is issued the next cycle.
  - Pop and push in the redirect cycle are ignored.
- Back-to-back redirects: the latest target wins; drop accumulates correctly.
- stall_f with an empty queue: no effect; fetching continues until the queue is full.
- Latency: redirect to valid_f = 1 (issue) + memory latency + 1 (FIFO register). With a 1-cycle memory and gnt=1, the minimum is 3 cycles.
- Counters are sized clog2(N)+1; none may exceed its bound (add assertions).

Test Plan:
- Reset release, gnt=1, 1-cycle memory, stall_f=0 -> imem_addr 0,4,8,...; valid_f first high cycle 3; pc_plus_4_f 4,8,12 on consecutive cycles.
- stall_f held high 10 cycles -> exactly QUEUE_DEPTH=4 entries fetched, imem_req drops to 0, head stays pc_plus_4_f=4. Release -> 4,8,12,16 drain with no bubble.
- Memory latency 3, gnt=1 -> never more than 2 outstanding; throughput 2 instr / 3 cycles; order preserved.
- pc_src_d=1, pc_branch_d=0x100 while 2 requests outstanding -> both responses discarded; next imem_addr=0x100; first valid pc_plus_4_f=0x104.
- pc_branch_d=0x103 -> imem_addr=0x100. Redirect coinciding with rvalid and gnt -> response dropped, drop count correct, no stale instruction appears.
- reset_n low mid-burst with responses pending -> all outputs zero immediately; after release, fetch restarts at RESET_VECTOR.
